// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds requester state encoding, ALU selects and branch helpers.
package alu_arbiter_pkg;

  localparam int NUM_ALU_REQ = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    INFLIGHT = 2'd1,
    RESP     = 2'd2
  } arb_state_e;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_SLL   = 4'd2,
    ALU_SLT   = 4'd3,
    ALU_SLTU  = 4'd4,
    ALU_XOR   = 4'd5,
    ALU_SRL   = 4'd6,
    ALU_SRA   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_AND   = 4'd9,
    ALU_PASS  = 4'd10,
    ALU_PCADD = 4'd11
  } alu_sel_e;

  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  function automatic logic br_cond(
    input logic [2:0] f3,
    input logic       eq,
    input logic       lt,
    input logic       ltu
  );
    logic r;
    case (f3)
      3'b000:  r = eq;
      3'b001:  r = !eq;
      3'b100:  r = lt;
      3'b101:  r = !lt;
      3'b110:  r = ltu;
      3'b111:  r = !ltu;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Request/response bundle between issue, the arbiter and writeback.
// Signal names follow the arbiter's external port naming.
interface alu_arbiter_if
  import alu_arbiter_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);

  logic [NUM_ALU_REQ-1:0]             req_valid_i;
  logic [NUM_ALU_REQ-1:0]             req_ready_o;
  logic [NUM_ALU_REQ-1:0][AWIDTH-1:0] req_pc_i;
  logic [NUM_ALU_REQ-1:0][DWIDTH-1:0] req_rs1_i;
  logic [NUM_ALU_REQ-1:0][DWIDTH-1:0] req_rs2_i;
  logic [NUM_ALU_REQ-1:0][6:0]        req_opcode_i;
  logic [NUM_ALU_REQ-1:0][2:0]        req_funct3_i;
  logic [NUM_ALU_REQ-1:0][6:0]        req_funct7_i;
  logic [NUM_ALU_REQ-1:0][3:0]        req_alusel_i;
  logic [NUM_ALU_REQ-1:0]             resp_valid_o;
  logic [NUM_ALU_REQ-1:0]             resp_ready_i;
  logic [NUM_ALU_REQ-1:0][DWIDTH-1:0] resp_data_o;

  modport master (
    output req_valid_i, req_pc_i,
    output req_rs1_i, req_rs2_i,
    output req_opcode_i, req_funct3_i,
    output req_funct7_i, req_alusel_i,
    output resp_ready_i,
    input  req_ready_o, resp_valid_o,
    input  resp_data_o
  );

  modport slave (
    input  req_valid_i, req_pc_i,
    input  req_rs1_i, req_rs2_i,
    input  req_opcode_i, req_funct3_i,
    input  req_funct7_i, req_alusel_i,
    input  resp_ready_i,
    output req_ready_o, resp_valid_o,
    output resp_data_o
  );

endinterface

// File: rtl/alu_arbiter_alu.sv
// Execute-stage ALU: purely combinational result and branch compare.
// Operand widths and wrap-around are the natural DWIDTH arithmetic.
module alu_arbiter_alu
  import alu_arbiter_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic [AWIDTH-1:0] pc_i,
  input  logic [DWIDTH-1:0] rs1_i,
  input  logic [DWIDTH-1:0] rs2_i,
  input  logic [6:0]        opcode_i,
  input  logic [2:0]        funct3_i,
  input  logic [6:0]        funct7_i,
  input  logic [3:0]        alusel_i,
  output logic [DWIDTH-1:0] res_o,
  output logic              brtaken_o
);

  localparam int SW = $clog2(DWIDTH);

  logic [SW-1:0] w_shamt;
  logic          w_eq;
  logic          w_lt;
  logic          w_ltu;
  logic          w_unused_f7;

  assign w_shamt = rs2_i[SW-1:0];
  assign w_eq    = (rs1_i == rs2_i);
  assign w_lt    = ($signed(rs1_i) < $signed(rs2_i));
  assign w_ltu   = (rs1_i < rs2_i);

  // funct7 is already folded into alusel by decode
  assign w_unused_f7 = ^funct7_i;

  always_comb begin
    res_o = '0;
    unique case (alusel_i)
      ALU_ADD:   res_o = rs1_i + rs2_i;
      ALU_SUB:   res_o = rs1_i - rs2_i;
      ALU_SLL:   res_o = rs1_i << w_shamt;
      ALU_SLT:   res_o = {{(DWIDTH-1){1'b0}}, w_lt};
      ALU_SLTU:  res_o = {{(DWIDTH-1){1'b0}}, w_ltu};
      ALU_XOR:   res_o = rs1_i ^ rs2_i;
      ALU_SRL:   res_o = rs1_i >> w_shamt;
      ALU_SRA:   res_o = $signed(rs1_i) >>> w_shamt;
      ALU_OR:    res_o = rs1_i | rs2_i;
      ALU_AND:   res_o = rs1_i & rs2_i;
      ALU_PASS:  res_o = rs2_i;
      ALU_PCADD: res_o = DWIDTH'(pc_i) + rs2_i;
      default:   res_o = '0;
    endcase
  end

  assign brtaken_o = (opcode_i == OP_BRANCH)
                   && br_cond(funct3_i, w_eq, w_lt, w_ltu);

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin share of the execute ALU between issue and aux paths.
// One-entry operand stage feeds the ALU; results land in per-req buffers.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input logic         clk,
  input logic         reset,
  alu_arbiter_if.slave bus
);

  arb_state_e r_state [NUM_ALU_REQ];
  arb_state_e w_state_nxt [NUM_ALU_REQ];

  logic [NUM_ALU_REQ-1:0] w_elig;
  logic [NUM_ALU_REQ-1:0] w_ready;
  logic [NUM_ALU_REQ-1:0] w_rvalid;
  logic [NUM_ALU_REQ-1:0] w_acc;
  logic [NUM_ALU_REQ-1:0] w_hs;
  logic                   w_sel;

  logic                   r_last;
  logic                   r_s_vld;
  logic                   r_s_owner;
  logic [AWIDTH-1:0]      r_s_pc;
  logic [DWIDTH-1:0]      r_s_rs1;
  logic [DWIDTH-1:0]      r_s_rs2;
  logic [6:0]             r_s_opcode;
  logic [2:0]             r_s_funct3;
  logic [6:0]             r_s_funct7;
  logic [3:0]             r_s_alusel;

  logic [NUM_ALU_REQ-1:0][DWIDTH-1:0] r_data;

  logic [DWIDTH-1:0]      w_alu_res;
  logic                   w_alu_br;
  logic                   w_unused_br;

  // state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ALU_REQ; i++) begin
      if (reset) r_state[i] <= IDLE;
      else       r_state[i] <= w_state_nxt[i];
    end
  end

  // next state
  always_comb begin
    for (int i = 0; i < NUM_ALU_REQ; i++) begin
      w_state_nxt[i] = r_state[i];
      unique case (r_state[i])
        IDLE:     if (w_acc[i]) w_state_nxt[i] = INFLIGHT;
        INFLIGHT: w_state_nxt[i] = RESP;
        RESP: begin
          if (w_hs[i])
            w_state_nxt[i] = w_acc[i] ? INFLIGHT : IDLE;
        end
        default:  w_state_nxt[i] = IDLE;
      endcase
    end
  end

  // outputs: eligibility, grant, response valid
  always_comb begin
    w_elig   = '0;
    w_rvalid = '0;
    w_ready  = '0;
    for (int i = 0; i < NUM_ALU_REQ; i++) begin
      w_rvalid[i] = (r_state[i] == RESP);
      w_elig[i]   = bus.req_valid_i[i]
                  && ((r_state[i] == IDLE)
                  || (w_rvalid[i] && bus.resp_ready_i[i]));
    end
    if (!reset) begin
      unique case (w_elig)
        2'b11:   w_ready = r_last ? 2'b01 : 2'b10;
        2'b01:   w_ready = 2'b01;
        2'b10:   w_ready = 2'b10;
        default: w_ready = 2'b00;
      endcase
    end
  end

  assign w_acc = w_ready & bus.req_valid_i;
  assign w_hs  = w_rvalid & bus.resp_ready_i;
  assign w_sel = w_acc[1];

  assign bus.req_ready_o  = w_ready;
  assign bus.resp_valid_o = w_rvalid;
  assign bus.resp_data_o  = r_data;

  // owner's buffer is always free when its stage slot is valid
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s_vld    <= 1'b0;
      r_s_owner  <= 1'b0;
      r_last     <= 1'b1;
      r_s_pc     <= '0;
      r_s_rs1    <= '0;
      r_s_rs2    <= '0;
      r_s_opcode <= '0;
      r_s_funct3 <= '0;
      r_s_funct7 <= '0;
      r_s_alusel <= '0;
      r_data     <= '0;
    end else begin
      r_s_vld <= |w_acc;
      if (|w_acc) begin
        r_s_owner  <= w_sel;
        r_last     <= w_sel;
        r_s_pc     <= bus.req_pc_i[w_sel];
        r_s_rs1    <= bus.req_rs1_i[w_sel];
        r_s_rs2    <= bus.req_rs2_i[w_sel];
        r_s_opcode <= bus.req_opcode_i[w_sel];
        r_s_funct3 <= bus.req_funct3_i[w_sel];
        r_s_funct7 <= bus.req_funct7_i[w_sel];
        r_s_alusel <= bus.req_alusel_i[w_sel];
      end
      if (r_s_vld) r_data[r_s_owner] <= w_alu_res;
    end
  end

  alu_arbiter_alu #(
    .DWIDTH (DWIDTH),
    .AWIDTH (AWIDTH)
  ) u_alu (
    .pc_i      (r_s_pc),
    .rs1_i     (r_s_rs1),
    .rs2_i     (r_s_rs2),
    .opcode_i  (r_s_opcode),
    .funct3_i  (r_s_funct3),
    .funct7_i  (r_s_funct7),
    .alusel_i  (r_s_alusel),
    .res_o     (w_alu_res),
    .brtaken_o (w_alu_br)
  );

  assign w_unused_br = w_alu_br;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus a random run
// scored against a cycle-level model of the handshake rules.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  alu_arbiter_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  alu_arbiter #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] ref_alu(
    input logic [3:0]  sel,
    input logic [31:0] pc,
    input logic [31:0] a,
    input logic [31:0] b
  );
    logic [4:0] sh;
    sh = b[4:0];
    case (sel)
      ALU_ADD:   return a + b;
      ALU_SUB:   return a - b;
      ALU_SLL:   return a << sh;
      ALU_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLTU:  return (a < b) ? 32'd1 : 32'd0;
      ALU_XOR:   return a ^ b;
      ALU_SRL:   return a >> sh;
      ALU_SRA:   return $signed(a) >>> sh;
      ALU_OR:    return a | b;
      ALU_AND:   return a & b;
      ALU_PASS:  return b;
      ALU_PCADD: return pc + b;
      default:   return 32'd0;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    bus.req_valid_i  = '0;
    bus.resp_ready_i = '0;
    bus.req_pc_i     = '0;
    bus.req_rs1_i    = '0;
    bus.req_rs2_i    = '0;
    bus.req_opcode_i = '0;
    bus.req_funct3_i = '0;
    bus.req_funct7_i = '0;
    bus.req_alusel_i = '0;
  endtask

  task automatic set_op(
    input int          i,
    input logic [3:0]  sel,
    input logic [31:0] a,
    input logic [31:0] b
  );
    bus.req_alusel_i[i] = sel;
    bus.req_rs1_i[i]    = a;
    bus.req_rs2_i[i]    = b;
    bus.req_pc_i[i]     = 32'h0;
    bus.req_opcode_i[i] = 7'h33;
    bus.req_funct3_i[i] = 3'h0;
    bus.req_funct7_i[i] = 7'h0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_in();
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_op(0, ALU_ADD, 32'd1, 32'd2);
    set_op(1, ALU_ADD, 32'd3, 32'd4);
    bus.req_valid_i  = 2'b11;
    bus.resp_ready_i = 2'b11;
    tick();
    tick();
    nchk++;
    if (bus.req_ready_o !== 2'b00) begin
      nerr++;
      $display("FAIL rst_ready: got %b want 00", bus.req_ready_o);
    end
    nchk++;
    if (bus.resp_valid_o !== 2'b00) begin
      nerr++;
      $display("FAIL rst_rvalid: got %b want 00", bus.resp_valid_o);
    end
    nchk++;
    if (bus.resp_data_o !== 64'h0) begin
      nerr++;
      $display("FAIL rst_data: got %h want 0", bus.resp_data_o);
    end
    reset = 1'b0;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL rst_first_tie: got %b want 01", bus.req_ready_o);
    end
    tick();
  endtask

  task automatic test_single();
    do_reset();
    set_op(0, ALU_ADD, 32'd5, 32'd7);
    bus.req_valid_i  = 2'b01;
    bus.resp_ready_i = 2'b11;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL single_acc: got %b want 01", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    nchk++;
    if (bus.resp_valid_o !== 2'b00) begin
      nerr++;
      $display("FAIL single_e1: got %b want 00", bus.resp_valid_o);
    end
    tick();
    #1;
    nchk++;
    if (bus.resp_valid_o !== 2'b01 || bus.resp_data_o[0] !== 32'd12) begin
      nerr++;
      $display("FAIL single_e2: got v=%b d=%0d want v=01 d=12",
               bus.resp_valid_o, bus.resp_data_o[0]);
    end
    tick();
    #1;
    nchk++;
    if (bus.resp_valid_o !== 2'b00) begin
      nerr++;
      $display("FAIL single_e3: got %b want 00", bus.resp_valid_o);
    end
  endtask

  task automatic test_tie();
    int g[$];
    do_reset();
    set_op(0, ALU_SUB, 32'd10, 32'd3);
    set_op(1, ALU_XOR, 32'hF0, 32'h0F);
    bus.req_valid_i  = 2'b11;
    bus.resp_ready_i = 2'b11;
    for (int k = 0; k < 8; k++) begin
      #1;
      nchk++;
      if ($countones(bus.req_ready_o) > 1) begin
        nerr++;
        $display("FAIL tie_onehot: got %b want <=1 bit",
                 bus.req_ready_o);
      end
      if (bus.req_ready_o == 2'b01) g.push_back(0);
      if (bus.req_ready_o == 2'b10) g.push_back(1);
      if (bus.resp_valid_o[0]) begin
        nchk++;
        if (bus.resp_data_o[0] !== 32'd7) begin
          nerr++;
          $display("FAIL tie_d0: got %h want 7", bus.resp_data_o[0]);
        end
      end
      if (bus.resp_valid_o[1]) begin
        nchk++;
        if (bus.resp_data_o[1] !== 32'hFF) begin
          nerr++;
          $display("FAIL tie_d1: got %h want ff", bus.resp_data_o[1]);
        end
      end
      tick();
    end
    nchk++;
    if (g.size() != 8) begin
      nerr++;
      $display("FAIL tie_rate: got %0d grants want 8", g.size());
    end
    for (int j = 0; j < 4; j++) begin
      nchk++;
      if (j >= g.size() || g[j] != (j % 2)) begin
        nerr++;
        $display("FAIL tie_order: slot %0d got %0d want %0d", j,
                 (j < g.size()) ? g[j] : -1, j % 2);
      end
    end
    idle_in();
  endtask

  task automatic test_backpressure();
    int g1 = 0;
    do_reset();
    set_op(0, ALU_OR, 32'h1, 32'h2);
    set_op(1, ALU_ADD, 32'd20, 32'd22);
    bus.req_valid_i  = 2'b01;
    bus.resp_ready_i = 2'b00;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL bp_acc: got %b want 01", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i  = 2'b11;
    bus.resp_ready_i = 2'b10;
    for (int k = 0; k < 7; k++) begin
      #1;
      nchk++;
      if (bus.req_ready_o[0] !== 1'b0) begin
        nerr++;
        $display("FAIL bp_rdy0: cyc %0d got 1 want 0", k);
      end
      if (k >= 1) begin
        nchk++;
        if (bus.resp_valid_o[0] !== 1'b1
            || bus.resp_data_o[0] !== 32'h3) begin
          nerr++;
          $display("FAIL bp_hold: cyc %0d got v=%b d=%h want v=1 d=3",
                   k, bus.resp_valid_o[0], bus.resp_data_o[0]);
        end
      end
      if (bus.resp_valid_o[1]) begin
        nchk++;
        if (bus.resp_data_o[1] !== 32'd42) begin
          nerr++;
          $display("FAIL bp_d1: got %0d want 42", bus.resp_data_o[1]);
        end
      end
      if (bus.req_ready_o[1]) g1++;
      tick();
    end
    nchk++;
    if (g1 < 3) begin
      nerr++;
      $display("FAIL bp_req1: got %0d grants want >=3", g1);
    end
    bus.resp_ready_i = 2'b11;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL bp_release: got %b want 01", bus.req_ready_o);
    end
    tick();
    idle_in();
  endtask

  task automatic test_back_to_back();
    do_reset();
    set_op(0, ALU_SLL, 32'd1, 32'd4);
    bus.req_valid_i  = 2'b01;
    bus.resp_ready_i = 2'b11;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL b2b_acc1: got %b want 01", bus.req_ready_o);
    end
    tick();
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b00 || bus.resp_valid_o !== 2'b00) begin
      nerr++;
      $display("FAIL b2b_e1: got r=%b v=%b want r=00 v=00",
               bus.req_ready_o, bus.resp_valid_o);
    end
    set_op(0, ALU_SLL, 32'd1, 32'd5);
    tick();
    #1;
    nchk++;
    if (bus.resp_valid_o !== 2'b01 || bus.resp_data_o[0] !== 32'h10
        || bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL b2b_e2: got v=%b d=%h r=%b want v=01 d=10 r=01",
               bus.resp_valid_o, bus.resp_data_o[0], bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 2'b00;
    #1;
    nchk++;
    if (bus.resp_valid_o !== 2'b00) begin
      nerr++;
      $display("FAIL b2b_e3: got %b want 00", bus.resp_valid_o);
    end
    tick();
    #1;
    nchk++;
    if (bus.resp_valid_o !== 2'b01 || bus.resp_data_o[0] !== 32'h20) begin
      nerr++;
      $display("FAIL b2b_e4: got v=%b d=%h want v=01 d=20",
               bus.resp_valid_o, bus.resp_data_o[0]);
    end
    tick();
    idle_in();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_op(1, ALU_PASS, 32'h0, 32'hDEAD);
    bus.req_valid_i  = 2'b10;
    bus.resp_ready_i = 2'b11;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b10) begin
      nerr++;
      $display("FAIL rm_acc: got %b want 10", bus.req_ready_o);
    end
    tick();
    reset = 1'b1;
    bus.req_valid_i = 2'b11;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b00) begin
      nerr++;
      $display("FAIL rm_rdy_rst: got %b want 00", bus.req_ready_o);
    end
    tick();
    reset = 1'b0;
    bus.req_valid_i = 2'b00;
    for (int k = 0; k < 4; k++) begin
      #1;
      nchk++;
      if (bus.resp_valid_o !== 2'b00 || bus.resp_data_o !== 64'h0) begin
        nerr++;
        $display("FAIL rm_quiet: cyc %0d got v=%b d=%h want 0",
                 k, bus.resp_valid_o, bus.resp_data_o);
      end
      tick();
    end
    bus.req_valid_i = 2'b11;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL rm_tie: got %b want 01", bus.req_ready_o);
    end
    tick();
    idle_in();
  endtask

  task automatic test_shift();
    do_reset();
    set_op(0, ALU_SRA, 32'h80000000, 32'd31);
    bus.req_valid_i  = 2'b01;
    bus.resp_ready_i = 2'b01;
    #1;
    nchk++;
    if (bus.req_ready_o !== 2'b01) begin
      nerr++;
      $display("FAIL sra_acc: got %b want 01", bus.req_ready_o);
    end
    tick();
    bus.req_valid_i = 2'b00;
    tick();
    #1;
    nchk++;
    if (bus.resp_valid_o !== 2'b01
        || bus.resp_data_o[0] !== 32'hFFFFFFFF) begin
      nerr++;
      $display("FAIL sra_res: got v=%b d=%h want v=01 d=ffffffff",
               bus.resp_valid_o, bus.resp_data_o[0]);
    end
    tick();
    idle_in();
  endtask

  task automatic test_random();
    bit          pend [2];
    int          acc  [2];
    logic [31:0] expd [2];
    logic [3:0]  sel  [2];
    logic [31:0] pc   [2];
    logic [31:0] a    [2];
    logic [31:0] b    [2];
    int          last;
    logic [1:0]  v, rr, ev, el, er;
    do_reset();
    pend = '{0, 0};
    acc  = '{0, 0};
    last = 1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 2; i++) begin
        v[i]   = ($urandom_range(0, 3) != 0);
        rr[i]  = ($urandom_range(0, 2) != 0);
        sel[i] = 4'($urandom_range(0, 12));
        pc[i]  = $urandom;
        a[i]   = $urandom;
        b[i]   = ($urandom_range(0, 1) != 0) ? $urandom
                                              : 32'($urandom_range(0, 40));
        bus.req_alusel_i[i] = sel[i];
        bus.req_pc_i[i]     = pc[i];
        bus.req_rs1_i[i]    = a[i];
        bus.req_rs2_i[i]    = b[i];
        bus.req_opcode_i[i] = ($urandom_range(0, 1) != 0) ? OP_BRANCH
                                                          : 7'h33;
        bus.req_funct3_i[i] = 3'($urandom_range(0, 7));
        bus.req_funct7_i[i] = 7'($urandom_range(0, 127));
      end
      bus.req_valid_i  = v;
      bus.resp_ready_i = rr;
      #1;
      for (int i = 0; i < 2; i++) begin
        ev[i] = pend[i] && (c >= acc[i] + 2);
        el[i] = v[i] && (!pend[i] || (ev[i] && rr[i]));
      end
      if (el == 2'b11) er = (last == 1) ? 2'b01 : 2'b10;
      else             er = el;
      nchk++;
      if (bus.resp_valid_o !== ev) begin
        nerr++;
        $display("FAIL rnd_rvalid: cyc %0d got %b want %b",
                 c, bus.resp_valid_o, ev);
      end
      nchk++;
      if (bus.req_ready_o !== er) begin
        nerr++;
        $display("FAIL rnd_ready: cyc %0d got %b want %b",
                 c, bus.req_ready_o, er);
      end
      for (int i = 0; i < 2; i++) begin
        if (ev[i]) begin
          nchk++;
          if (bus.resp_data_o[i] !== expd[i]) begin
            nerr++;
            $display("FAIL rnd_data%0d: cyc %0d got %h want %h",
                     i, c, bus.resp_data_o[i], expd[i]);
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (ev[i] && rr[i]) pend[i] = 1'b0;
        if (er[i]) begin
          pend[i] = 1'b1;
          acc[i]  = c;
          expd[i] = ref_alu(sel[i], pc[i], a[i], b[i]);
          last    = i;
        end
      end
      tick();
    end
    idle_in();
  endtask

  initial begin
    idle_in();
    test_reset();
    test_single();
    test_tie();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_shift();
    test_random();
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single execute-stage `alu` between two requesters: requester 0 is the main pipeline issue slot and requester 1 is the auxiliary address/branch-target path. The block accepts operand bundles with a valid/ready handshake and grants the ALU round-robin. It runs the granted operation through a one-entry operand stage and returns the result in a per-requester response buffer with its own valid/ready handshake. It sits between decode/issue and writeback and is the only instantiator of `alu`.

## Interface
- `DWIDTH`, 32, data width of operands and result
- `AWIDTH`, 32, PC width
- `clk`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `req_valid_i`  in  [1:0]  request valid, one bit per requester
- `req_ready_o`  out  [1:0]  grant; a request is accepted when the valid and ready bits of the same requester are both high at a rising edge
- `req_pc_i`  in  [1:0][AWIDTH-1:0]  PC operand
- `req_rs1_i`, `req_rs2_i`  in  [1:0][DWIDTH-1:0]  source operands; rs2 is already muxed with the immediate upstream
- `req_opcode_i`  in  [1:0][6:0]  opcode
- `req_funct3_i`  in  [1:0][2:0]  funct3
- `req_funct7_i`  in  [1:0][6:0]  funct7
- `req_alusel_i`  in  [1:0][3:0]  ALU operation select (`ALU_*` encoding)
- `resp_valid_o`  out  [1:0]  result available for that requester
- `resp_ready_i`  in  [1:0]  requester consumes the result
- `resp_data_o`  out  [1:0][DWIDTH-1:0]  ALU result

## Operation
- **Per-requester state**, encoded as `arb_state_e`:
  - IDLE → INFLIGHT on accept.
  - INFLIGHT → RESP after one cycle, when the stage writes that requester's buffer.
  - RESP → IDLE on `resp_valid_o[i] && resp_ready_i[i]`.
  - RESP → INFLIGHT when the response handshake and a new accept for the same requester happen in the same cycle.
  - Each requester has at most one operation outstanding.
- **Eligibility:** requester i is eligible if `req_valid_i[i]` and either (state == IDLE) or (state == RESP and `resp_ready_i[i]` is high this cycle).
- **Grant:**
  - At most one `req_ready_o` bit is high per cycle.
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester not granted most recently wins.
  - The `last_grant` pointer updates only on an accept.
- `req_ready_o[i]` is combinational from eligibility and `last_grant`. It may depend on `req_valid_i` and `resp_ready_i`.
- **Stage register:**
  - On accept, the granted bundle is latched with `s_vld = 1` and `s_owner = i`.
  - If nothing is accepted, `s_vld = 0`.
  - The stage never stalls, because the owner's buffer is guaranteed free.
- **ALU:**
  - The `alu` is driven from the stage register only.
  - `res_o` is captured into `resp_data_o[s_owner]` and `resp_valid_o[s_owner]` is set when `s_vld` is high.
  - `brtaken_o` is not consumed here.
- **Response buffers:** `resp_data_o[i]` holds its value until the next write. Changing it while `resp_valid_o[i]` is high and not yet consumed is a bug.
- **Arithmetic:** all widths and wrap-around behaviour are those of `alu`. The arbiter never alters operands.

## Timing
- **Latency:** accept at edge E; stage valid during cycle E+1; `resp_valid_o` high from E+2.
- **Throughput:**
  - 1 op/cycle aggregate when the two requesters alternate.
  - 1 op per 2 cycles for a single requester that consumes its response in the first cycle it is valid, using the same-cycle drain-and-accept path.
- **Reset (synchronous):**
  - All requesters go to IDLE.
  - `s_vld = 0`.
  - `last_grant = 1`, so requester 0 wins the first tie.
  - `resp_valid_o = 0` and `resp_data_o = 0`.
  - `req_ready_o = 0` while `reset` is high.
- **Reset mid-operation:** in-flight and buffered results are discarded with no response. The first accept is possible in the cycle after `reset` deasserts.
- **Simultaneous events:**
  - Stage write and response handshake on different requesters are independent.
  - A same-requester handshake in cycle E+2 with a new accept in cycle E+2 gives the next response valid at E+4.
- **Unused inputs:** `req_valid_i` deasserted without an accept is legal and leaves no state behind.

## Structure
- Shared package (`constants.svh`):
  - Add `arb_state_e` (IDLE, INFLIGHT, RESP) and `NUM_ALU_REQ = 2`.
  - Reuse the existing `ALU_*` and opcode constants.
- The single sub-module is the existing `alu`, instantiated once and fed only from the stage register.
- Arbitration logic and response buffers stay in this module; no further sub-modules.

## Test plan
- **Single op:** reset, then req0 with `ALU_ADD`, rs1=5, rs2=7, `resp_ready_i` held high → accept at E; `resp_valid_o[0]` high only in cycle E+2 with data 12; `resp_valid_o[1]` stays 0.
- **Tie:** both requesters valid continuously with `ALU_SUB` 10−3 (req0) and `ALU_XOR` 0xF0^0x0F (req1) → grants in order 0,1,0,1; results 7 and 0xFF; never two ready bits high at once.
- **Backpressure:** req0 issues `ALU_OR` 0x1|0x2 with `resp_ready_i[0] = 0` for 5 cycles → `resp_valid_o[0]` stays high with data 0x3; `req_ready_o[0]` stays 0; req1 is still granted meanwhile.
- **Same-cycle drain and reaccept:** req0 back-to-back `ALU_SLL` 1<<4 then 1<<5, `resp_ready_i` high → second accept in the cycle the first response (0x10) is consumed; second response 0x20 two cycles later.
- **Reset mid-operation:** assert `reset` in the cycle after accepting req1's `ALU_PASS` with rs2=0xDEAD → no response is ever seen, all outputs are 0, and the next tie grants req0.
- **Shift width:** `ALU_SRA` with rs1=0x80000000 and rs2=31 → result 0xFFFFFFFF at E+2, unchanged by the arbiter.
